avalon_st_packet_enforcer: RTL and testbench
============================================

Name: avalon_st_packet_enforcer

Overview:
- Parametrised Avalon-ST protocol enforcer. It sits between an untrusted source and trusted downstream logic.
- Repairs framing violations (missing SOP, double SOP, oversize packets) so every packet delivered downstream is well formed (sop ... eop).
- Flags each violation with a one-cycle pulse and keeps saturating per-error counters for status reporting.
- A one-beat retention stage holds each beat back until its successor is known, so the block can insert an EOP on the held beat.

Parameters:
- DATA_WIDTH_IN_BYTES, 8, width of the data bus in bytes; empty width is $clog2(DATA_WIDTH_IN_BYTES).
- MAX_PKT_LEN_WORDS, 256, maximum accepted packet length in beats; must be >= 2.
- ABORT_ON_DOUBLE_SOP, 0, 0 = close the current packet and start the new one; 1 = close the current packet and discard the new one through its eop.
- ERR_CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- untrusted_msg  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  unchecked input stream
- enforced_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES  repaired output stream
- clear_cnt  in  1  synchronous clear of all three counters
- missing_sop_error  out  1  one-cycle pulse
- double_sop_error  out  1  one-cycle pulse
- oversize_error  out  1  one-cycle pulse
- missing_sop_cnt  out  ERR_CNT_WIDTH  saturating count
- double_sop_cnt  out  ERR_CNT_WIDTH  saturating count
- oversize_cnt  out  ERR_CNT_WIDTH  saturating count

Behaviour:
- Reset: state IDLE, hold register empty (H_valid=0), beat count 0, all pulses 0, all counters 0, enforced_msg.valid=0.
- Reset mid-packet discards the held beat; the packet already sent downstream stays unterminated, which is accepted system behaviour.
- An input beat is accepted when in.valid && in.ready.
- Hold register H stores one beat (data, sop, eop, empty).
- Output presentation: enforced.valid = H_valid && (H.eop || a new beat is being accepted this cycle that releases H).
- A non-eop held beat is never offered without a following beat.
- in.ready = !H_valid || enforced.ready || (the incoming beat is dropped and H does not need to move).
- in.ready may depend combinationally on in.valid and enforced.ready.
- Latency: a beat appears at the output once its successor is accepted; an eop beat appears the cycle after acceptance.
- State IDLE:
  - sop beat: load H, count=1, go to IN_PKT (or straight back to IDLE if the beat also carries eop).
  - Non-sop beat: consumed and dropped; missing_sop_error pulse.
- State IN_PKT:
  - Normal beat: H is released and the new beat is loaded; count++.
  - eop beat: load H and go to IDLE.
  - sop beat: double_sop_error pulse; H is released with eop forced to 1 and empty forced to 0.
    - ABORT_ON_DOUBLE_SOP=0: the new beat is loaded as the start of a new packet, count=1.
    - ABORT_ON_DOUBLE_SOP=1: the new beat is dropped; go to DROP (or IDLE if the beat carries eop).
  - Accepting beat number MAX_PKT_LEN_WORDS without eop: that beat gets eop forced to 1 and empty to 0; oversize_error pulse; go to DROP.
- State DROP:
  - Beats are consumed and dropped, with no error pulses.
  - An eop beat ends DROP and returns to IDLE.
  - A sop beat exits DROP and is treated as a fresh IDLE sop.
- empty is passed through on eop beats and forced to 0 on non-eop beats.
- Pulses are registered and assert the cycle after the offending acceptance.
- Counters: each counter increments with its pulse and saturates at all-ones.
- clear_cnt has priority over a simultaneous increment, so the result is 0.
- Backpressure: while enforced.ready=0 and H must move, in.ready=0, so no beat is lost or duplicated.

Decomposition:
- Package avalon_enforcer_pkg holds:
  - enum enforcer_state_t {IDLE, IN_PKT, DROP}
  - a held-beat struct typedef
  - a counter-width helper function
- Sub-module sat_counter (parameter WIDTH; inputs inc and clr; output cnt), instantiated three times.

Test Plan:
- Clean packet: sop beat 0x22.., 2 middle beats, eop with empty=3 -> 4 identical beats out, no pulses, all counters 0.
- Beat with no sop in IDLE (data 0x11..) -> beat dropped, missing_sop_error high for exactly one cycle, missing_sop_cnt=1.
- ABORT_ON_DOUBLE_SOP=0: sop A, A2, sop B, B2+eop -> output A, A2 with eop=1, then B, B2 with eop=1; double_sop_cnt=1.
- ABORT_ON_DOUBLE_SOP=1: same stimulus -> output A, A2 with eop=1 only; B and B2 dropped.
- MAX_PKT_LEN_WORDS=4: 6-beat packet -> 4 beats out, 4th has eop=1 and empty=0; beats 5-6 dropped; oversize_cnt=1.
- Backpressure plus counters:
  - Random enforced.ready (50%) during a clean packet -> output data order intact, no beat lost.
  - Force 2^16+3 missing-SOP beats -> cnt=0xFFFF; assert clear_cnt -> cnt=0.

Source files
------------

// File: rtl/avalon_enforcer_pkg.sv
// Shared types and sizing helpers for the Avalon-ST packet enforcer.
package avalon_enforcer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_PKT,
        DROP
    } enforcer_state_t;

    // Framing flags of the held beat; data and empty are sized by the instantiating module.
    typedef struct packed {
        logic sop;
        logic eop;
    } held_ctl_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned empty_width(input int unsigned bytes);
        return (bytes < 2) ? 1 : $clog2(bytes);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle with packet framing; master drives the beat, slave drives ready.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 8
);
    localparam int EMPTY_W = avalon_enforcer_pkg::empty_width(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             ready;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport master (output valid, data, sop, eop, empty, input ready);
    modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects inc one cycle later.
// Backpressure: none; clear wins over a simultaneous increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/avalon_st_packet_enforcer.sv
// Repairs Avalon-ST framing (missing/double sop, oversize) and counts each violation.
// Latency: a beat leaves once its successor is accepted; an eop beat leaves the next cycle.
// Backpressure: input stalls only when the held beat must move and downstream is not ready.
module avalon_st_packet_enforcer
    import avalon_enforcer_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 8,
    parameter int MAX_PKT_LEN_WORDS   = 256,
    parameter bit ABORT_ON_DOUBLE_SOP = 1'b0,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_st_if.slave               untrusted_msg,
    avalon_st_if.master              enforced_msg,
    input  logic                     clear_cnt,
    output logic                     missing_sop_error,
    output logic                     double_sop_error,
    output logic                     oversize_error,
    output logic [ERR_CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [ERR_CNT_WIDTH-1:0] double_sop_cnt,
    output logic [ERR_CNT_WIDTH-1:0] oversize_cnt
);
    localparam int DW = DATA_WIDTH_IN_BYTES * 8;
    localparam int EW = empty_width(DATA_WIDTH_IN_BYTES);
    localparam int CW = cnt_width(MAX_PKT_LEN_WORDS);

    typedef struct packed {
        logic [DW-1:0] data;
        held_ctl_t     ctl;
        logic [EW-1:0] empty;
    } held_beat_t;

    enforcer_state_t st, st_nxt;
    held_beat_t      h, in_beat, new_beat;
    logic            h_vld;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            load, miss, dbl, ovr, touches_h;
    logic            acc, out_fire, in_rdy, out_vld;

    always_comb begin
        in_beat.data    = untrusted_msg.data;
        in_beat.ctl.sop = untrusted_msg.sop;
        in_beat.ctl.eop = untrusted_msg.eop;
        in_beat.empty   = untrusted_msg.eop ? untrusted_msg.empty : '0;
        new_beat = in_beat;
        st_nxt   = st;
        cnt_nxt  = cnt;
        load     = 1'b0;
        miss     = 1'b0;
        dbl      = 1'b0;
        ovr      = 1'b0;
        if (st == IN_PKT && !untrusted_msg.sop) begin
            load    = 1'b1;
            cnt_nxt = cnt + CW'(1);
            if (untrusted_msg.eop) begin
                st_nxt = IDLE;
            end else if (cnt_nxt == CW'(MAX_PKT_LEN_WORDS)) begin
                new_beat.ctl.eop = 1'b1;
                new_beat.empty   = '0;
                ovr    = 1'b1;
                st_nxt = DROP;
            end
        end else if (st == IN_PKT) begin
            dbl = 1'b1;
            if (ABORT_ON_DOUBLE_SOP) begin
                st_nxt = untrusted_msg.eop ? IDLE : DROP;
            end else begin
                load    = 1'b1;
                cnt_nxt = CW'(1);
                st_nxt  = untrusted_msg.eop ? IDLE : IN_PKT;
            end
        end else if (untrusted_msg.sop) begin
            // A sop in DROP restarts framing exactly like a sop in IDLE.
            load    = 1'b1;
            cnt_nxt = CW'(1);
            st_nxt  = untrusted_msg.eop ? IDLE : IN_PKT;
        end else begin
            miss = (st == IDLE);
            if (untrusted_msg.eop) begin
                st_nxt = IDLE;
            end
        end
    end

    // Only beats that load H or close the held packet need H to move out first.
    assign touches_h = load || dbl;
    assign out_vld   = h_vld && (h.ctl.eop || (untrusted_msg.valid && touches_h));
    assign in_rdy    = !h_vld || enforced_msg.ready || !touches_h;
    assign acc       = untrusted_msg.valid && in_rdy;
    assign out_fire  = out_vld && enforced_msg.ready;

    assign untrusted_msg.ready = in_rdy;
    assign enforced_msg.valid  = out_vld;
    assign enforced_msg.data   = h.data;
    assign enforced_msg.sop    = h.ctl.sop;
    assign enforced_msg.eop    = h.ctl.eop || (untrusted_msg.valid && dbl);
    assign enforced_msg.empty  = h.empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            st                <= IDLE;
            h                 <= '0;
            h_vld             <= 1'b0;
            cnt               <= '0;
            missing_sop_error <= 1'b0;
            double_sop_error  <= 1'b0;
            oversize_error    <= 1'b0;
        end else begin
            if (acc && load) begin
                h     <= new_beat;
                h_vld <= 1'b1;
            end else if (out_fire) begin
                h_vld <= 1'b0;
            end
            if (acc) begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
            end
            missing_sop_error <= acc && miss;
            double_sop_error  <= acc && dbl;
            oversize_error    <= acc && ovr;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_missing_cnt (
        .clk (clk), .rst (rst), .inc (missing_sop_error), .clr (clear_cnt), .cnt (missing_sop_cnt)
    );
    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_double_cnt (
        .clk (clk), .rst (rst), .inc (double_sop_error), .clr (clear_cnt), .cnt (double_sop_cnt)
    );
    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_oversize_cnt (
        .clk (clk), .rst (rst), .inc (oversize_error), .clr (clear_cnt), .cnt (oversize_cnt)
    );
endmodule

// File: tb/tb_avalon_st_packet_enforcer.sv
// Bench: two enforcers (abort=0/max=4 and abort=1/max=8) against a packet-level reference model.
module tb_avalon_st_packet_enforcer;
    localparam int DB = 8;
    localparam int DW = 64;
    localparam int EW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          in_vld [2];
    logic          in_sop [2];
    logic          in_eop [2];
    logic [DW-1:0] in_dat [2];
    logic [EW-1:0] in_emp [2];
    logic          in_rdy [2];
    logic          out_vld[2];
    logic          out_sop[2];
    logic          out_eop[2];
    logic [DW-1:0] out_dat[2];
    logic [EW-1:0] out_emp[2];
    logic          out_rdy[2] = '{1'b1, 1'b1};
    logic          bp_en  [2] = '{1'b0, 1'b0};
    logic          clr    [2];
    logic          err_p  [2][3];
    logic [15:0]   err_c  [2][3];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        avalon_st_if #(.DATA_WIDTH_IN_BYTES(DB)) in_if ();
        avalon_st_if #(.DATA_WIDTH_IN_BYTES(DB)) out_if ();
        assign in_if.valid  = in_vld[g];
        assign in_if.sop    = in_sop[g];
        assign in_if.eop    = in_eop[g];
        assign in_if.data   = in_dat[g];
        assign in_if.empty  = in_emp[g];
        assign in_rdy[g]    = in_if.ready;
        assign out_vld[g]   = out_if.valid;
        assign out_sop[g]   = out_if.sop;
        assign out_eop[g]   = out_if.eop;
        assign out_dat[g]   = out_if.data;
        assign out_emp[g]   = out_if.empty;
        assign out_if.ready = out_rdy[g];

        avalon_st_packet_enforcer #(
            .DATA_WIDTH_IN_BYTES (DB),
            .MAX_PKT_LEN_WORDS   (g == 0 ? 4 : 8),
            .ABORT_ON_DOUBLE_SOP (g == 1),
            .ERR_CNT_WIDTH       (16)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .untrusted_msg     (in_if),
            .enforced_msg      (out_if),
            .clear_cnt         (clr[g]),
            .missing_sop_error (err_p[g][0]),
            .double_sop_error  (err_p[g][1]),
            .oversize_error    (err_p[g][2]),
            .missing_sop_cnt   (err_c[g][0]),
            .double_sop_cnt    (err_c[g][1]),
            .oversize_cnt      (err_c[g][2])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference model: framing mode (0 idle, 1 open packet, 2 discarding), beats so far in the open packet.
    beat_t exp_q [2][$];
    int    m_mode[2] = '{0, 0};
    int    m_len [2] = '{0, 0};
    int    m_tot [2][3];
    int    m_cnt [2][3];
    int    seen  [2][3];
    int    n_out [2] = '{0, 0};

    initial begin
        for (int d = 0; d < 2; d++)
            for (int e = 0; e < 3; e++) begin
                m_tot[d][e] = 0;
                m_cnt[d][e] = 0;
                seen[d][e]  = 0;
            end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic note_err(input int d, input int e);
        m_tot[d][e]++;
        if (m_cnt[d][e] < 65535) m_cnt[d][e]++;
    endtask

    task automatic model_accept(input int d, input beat_t b);
        int    mx;
        beat_t o;
        beat_t t;
        mx = (d == 0) ? 4 : 8;
        o  = b;
        if (!b.eop) o.empty = '0;
        if (m_mode[d] == 2 && b.sop) m_mode[d] = 0;
        case (m_mode[d])
            0: begin
                if (b.sop) begin
                    exp_q[d].push_back(o);
                    m_len[d]  = 1;
                    m_mode[d] = b.eop ? 0 : 1;
                end else begin
                    note_err(d, 0);
                end
            end
            1: begin
                if (b.sop) begin
                    note_err(d, 1);
                    if (exp_q[d].size() > 0) begin
                        t = exp_q[d].pop_back();
                        t.eop   = 1'b1;
                        t.empty = '0;
                        exp_q[d].push_back(t);
                    end
                    if (d == 0) begin
                        exp_q[d].push_back(o);
                        m_len[d]  = 1;
                        m_mode[d] = b.eop ? 0 : 1;
                    end else begin
                        m_mode[d] = b.eop ? 0 : 2;
                    end
                end else begin
                    m_len[d]++;
                    if (b.eop) begin
                        exp_q[d].push_back(o);
                        m_mode[d] = 0;
                    end else if (m_len[d] == mx) begin
                        o.eop   = 1'b1;
                        o.empty = '0;
                        exp_q[d].push_back(o);
                        note_err(d, 2);
                        m_mode[d] = 2;
                    end else begin
                        exp_q[d].push_back(o);
                    end
                end
            end
            default: if (b.eop) m_mode[d] = 0;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (clr[d])
                    for (int e = 0; e < 3; e++) m_cnt[d][e] = 0;
                if (in_vld[d] && in_rdy[d])
                    model_accept(d, {in_dat[d], in_sop[d], in_eop[d], in_emp[d]});
                if (out_vld[d] && out_rdy[d]) begin
                    n_out[d]++;
                    if (exp_q[d].size() == 0)
                        chk($sformatf("d%0d_unexpected_beat", d), {out_dat[d], out_sop[d], out_eop[d], out_emp[d]}, '0);
                    else
                        chk($sformatf("d%0d_out_beat%0d", d, n_out[d]),
                            {out_dat[d], out_sop[d], out_eop[d], out_emp[d]}, exp_q[d].pop_front());
                end
                for (int e = 0; e < 3; e++)
                    if (err_p[d][e]) seen[d][e]++;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) out_rdy[d] = bp_en[d] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input int d, input logic s, input logic e, input logic [DW-1:0] dat, input logic [EW-1:0] emp);
        int t;
        t = 0;
        in_vld[d] = 1'b1;
        in_sop[d] = s;
        in_eop[d] = e;
        in_dat[d] = dat;
        in_emp[d] = emp;
        do begin
            @(negedge clk);
            t++;
        end while (!in_rdy[d] && t < 200);
        if (!in_rdy[d]) chk($sformatf("d%0d_accept_timeout", d), in_rdy[d], 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int d = 0; d < 2; d++) begin
            in_vld[d] = 1'b0;
            bp_en[d]  = 1'b0;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input int d, input string tag);
        chk($sformatf("d%0d_%s_pending", d, tag), exp_q[d].size(), 0);
        for (int e = 0; e < 3; e++) begin
            chk($sformatf("d%0d_%s_pulses%0d", d, tag, e), seen[d][e], m_tot[d][e]);
            chk($sformatf("d%0d_%s_cnt%0d", d, tag, e), err_c[d][e], m_cnt[d][e]);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int base;
        logic [DW-1:0] pat;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_vld[d] = 1'b0; in_sop[d] = 1'b0; in_eop[d] = 1'b0;
            in_dat[d] = '0;   in_emp[d] = '0;   clr[d]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_out_valid", d), out_vld[d], 1'b0);
            chk($sformatf("d%0d_rst_in_ready", d), in_rdy[d], 1'b1);
            for (int e = 0; e < 3; e++) begin
                chk($sformatf("d%0d_rst_pulse%0d", d, e), err_p[d][e], 1'b0);
                chk($sformatf("d%0d_rst_cnt%0d", d, e), err_c[d][e], 16'd0);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean 4-beat packet on both instances.
        for (int d = 0; d < 2; d++) begin
            base = n_out[d];
            pat  = {8{8'h22}};
            send(d, 1'b1, 1'b0, pat, 3'd0);
            send(d, 1'b0, 1'b0, pat + 64'd1, 3'd5);
            send(d, 1'b0, 1'b0, pat + 64'd2, 3'd0);
            send(d, 1'b0, 1'b1, pat + 64'd3, 3'd3);
            drain();
            chk($sformatf("d%0d_clean_beats", d), n_out[d] - base, 4);
            check_state(d, "clean");
        end

        // Stray non-sop beat in IDLE: one-cycle pulse.
        send(0, 1'b0, 1'b0, {8{8'h11}}, 3'd0);
        in_vld[0] = 1'b0;
        chk("missing_pulse_high", err_p[0][0], 1'b1);
        @(posedge clk);
        #1;
        chk("missing_pulse_low", err_p[0][0], 1'b0);
        drain();
        check_state(0, "missing");

        // Double sop: instance 0 restarts, instance 1 discards the new packet.
        for (int d = 0; d < 2; d++) begin
            base = n_out[d];
            send(d, 1'b1, 1'b0, 64'hA0, 3'd2);
            send(d, 1'b0, 1'b0, 64'hA2, 3'd4);
            send(d, 1'b1, 1'b0, 64'hB0, 3'd0);
            send(d, 1'b0, 1'b1, 64'hB2, 3'd6);
            drain();
            chk($sformatf("d%0d_dblsop_beats", d), n_out[d] - base, d == 0 ? 4 : 2);
            check_state(d, "dblsop");
        end

        // Oversize on instance 0 (limit 4 beats).
        base = n_out[0];
        for (int i = 0; i < 6; i++)
            send(0, i == 0, i == 5, 64'hC0 + 64'(i), 3'd1);
        drain();
        chk("oversize_beats", n_out[0] - base, 4);
        check_state(0, "oversize");

        // Randomised framing under 50% downstream backpressure.
        for (int d = 0; d < 2; d++) begin
            bp_en[d] = 1'b1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    in_vld[d] = 1'b0;
                    @(posedge clk);
                    #1;
                end
                send(d, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                     {$urandom, $urandom}, 3'($urandom));
            end
            send(d, 1'b1, 1'b1, {$urandom, $urandom}, 3'($urandom));
            drain();
            check_state(d, "random");
        end

        // Saturation of the missing-sop counter, then clear.
        for (int i = 0; i < 65539; i++)
            send(0, 1'b0, 1'b0, 64'(i), 3'd0);
        drain();
        chk("missing_cnt_saturated", err_c[0][0], 16'hFFFF);
        check_state(0, "saturate");
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        drain();
        chk("missing_cnt_cleared", err_c[0][0], 16'd0);

        // Clear coinciding with an increment leaves zero.
        send(0, 1'b0, 1'b0, 64'h55, 3'd0);
        in_vld[0] = 1'b0;
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        drain();
        chk("clear_beats_increment", err_c[0][0], 16'd0);
        check_state(0, "clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
